// File: rtl/rle_pkg.sv
// Shared state encoding, default widths and word-geometry helper for the
// run-length compressor.
package rle_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_COUNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    PROC,
    WR,
    FLUSH,
    DONE
  } state_t;

  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/rle_packer.sv
// Byte-to-word packer: bytes fill the word little-endian; unused upper bytes
// stay zero, so a partial word read out is already zero-padded.
module rle_packer import rle_pkg::*; #(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned NB     = bytes_per_word(DATA_W),
  localparam int unsigned CNT_W  = $clog2(NB + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic              clear,
  output logic              full,
  output logic [DATA_W-1:0] word,
  output logic [CNT_W-1:0]  byte_cnt
);

  assign full = (byte_cnt == CNT_W'(NB));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (in_valid && !full) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (byte_cnt == CNT_W'(i)) word[8*i +: 8] <= in_byte;
      end
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rle_engine.sv
// Run-length compressor over a single shared DPSRAM port: reads plaintext words,
// emits (count, symbol) byte pairs packed into words. Optional RLE_SIZE_HDR_EN.
module rle_engine import rle_pkg::*; #(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned COUNT_W = DEF_COUNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic [DATA_W-1:0] port_A_data_in,
  input  logic [DATA_W-1:0] port_A_data_out,
  output logic              port_A_we
);

  localparam int unsigned NB   = bytes_per_word(DATA_W);
  localparam int unsigned BI_W = $clog2(NB + 1);
`ifdef RLE_SIZE_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(NB);

  state_t state, state_n;

  logic [ADDR_W-1:0]  rd_addr, wr_addr, hdr_addr;
  logic [31:0]        remaining, msg_size_q;
  logic [DATA_W-1:0]  word_q, word_shift;
  logic [BI_W-1:0]    byte_idx, word_bytes, next_wb;
  logic [7:0]         cur_sym, cur_byte, cnt_byte, push_byte;
  logic [COUNT_W-1:0] cur_cnt;
  logic               have_run, emit_sym, hdr_done, wr_from_flush;
  logic               run_pending, hdr_pending;

  logic accept, capture, consume, run_new, run_inc, emit_set, emit_clr, run_end;
  logic push, pk_clear, word_wr, hdr_wr, to_wr;

  logic              pk_full;
  logic [DATA_W-1:0] pk_word;
  logic [BI_W-1:0]   pk_cnt;

  logic unused_hi;
  assign unused_hi = ^{message_addr, rle_addr};

  assign port_A_clk  = clk;
  assign done        = (state == DONE);
  assign word_shift  = word_q >> {byte_idx, 3'b000};
  assign cur_byte    = word_shift[7:0];
  assign cnt_byte    = 8'(cur_cnt);
  assign run_pending = have_run || emit_sym;
  assign hdr_pending = HDR_EN && !hdr_done;
  assign next_wb     = (remaining >= 32'(NB)) ? BI_W'(NB) : BI_W'(remaining);

  rle_packer #(.DATA_W(DATA_W)) u_packer (
    .clk      (clk),
    .reset    (reset),
    .in_valid (push),
    .in_byte  (push_byte),
    .clear    (pk_clear),
    .full     (pk_full),
    .word     (pk_word),
    .byte_cnt (pk_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // A run break takes two cycles: count byte first, then the symbol byte
  // together with starting the new run from the byte that broke it.
  always_comb begin
    state_n        = state;
    accept         = 1'b0;
    capture        = 1'b0;
    consume        = 1'b0;
    run_new        = 1'b0;
    run_inc        = 1'b0;
    emit_set       = 1'b0;
    emit_clr       = 1'b0;
    run_end        = 1'b0;
    push           = 1'b0;
    push_byte      = cnt_byte;
    pk_clear       = 1'b0;
    word_wr        = 1'b0;
    hdr_wr         = 1'b0;
    to_wr          = 1'b0;
    port_A_we      = 1'b0;
    port_A_addr    = '0;
    port_A_data_in = '0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          accept   = 1'b1;
          pk_clear = 1'b1;
          state_n  = (message_size == '0) ? FLUSH : RD_ADDR;
        end
      end
      RD_ADDR: begin
        port_A_addr = rd_addr;
        state_n     = RD_WAIT;
      end
      RD_WAIT: begin
        capture = 1'b1;
        state_n = PROC;
      end
      PROC: begin
        if (pk_full) begin
          to_wr   = 1'b1;
          state_n = WR;
        end else if (emit_sym) begin
          push      = 1'b1;
          push_byte = cur_sym;
          emit_clr  = 1'b1;
          run_new   = 1'b1;
          consume   = 1'b1;
        end else if (byte_idx < word_bytes) begin
          if (!have_run) begin
            run_new = 1'b1;
            consume = 1'b1;
          end else if (cur_byte == cur_sym && cur_cnt != '1) begin
            run_inc = 1'b1;
            consume = 1'b1;
          end else begin
            push     = 1'b1;
            emit_set = 1'b1;
          end
        end else begin
          state_n = (remaining == '0) ? FLUSH : RD_ADDR;
        end
      end
      WR: begin
        port_A_we      = 1'b1;
        port_A_addr    = wr_addr;
        port_A_data_in = pk_word;
        pk_clear       = 1'b1;
        word_wr        = 1'b1;
        if (!wr_from_flush)                  state_n = PROC;
        else if (run_pending || hdr_pending) state_n = FLUSH;
        else                                 state_n = DONE;
      end
      FLUSH: begin
        if (pk_full) begin
          to_wr   = 1'b1;
          state_n = WR;
        end else if (emit_sym) begin
          push      = 1'b1;
          push_byte = cur_sym;
          emit_clr  = 1'b1;
          run_end   = 1'b1;
        end else if (have_run) begin
          push     = 1'b1;
          emit_set = 1'b1;
        end else if (pk_cnt != '0) begin
          port_A_we      = 1'b1;
          port_A_addr    = wr_addr;
          port_A_data_in = pk_word;
          pk_clear       = 1'b1;
          word_wr        = 1'b1;
          state_n        = hdr_pending ? FLUSH : DONE;
        end else if (hdr_pending) begin
          port_A_we      = 1'b1;
          port_A_addr    = hdr_addr;
          port_A_data_in = DATA_W'(msg_size_q);
          hdr_wr         = 1'b1;
          state_n        = DONE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr       <= '0;
      wr_addr       <= '0;
      hdr_addr      <= '0;
      remaining     <= '0;
      msg_size_q    <= '0;
      word_q        <= '0;
      byte_idx      <= '0;
      word_bytes    <= '0;
      cur_sym       <= '0;
      cur_cnt       <= '0;
      have_run      <= 1'b0;
      emit_sym      <= 1'b0;
      hdr_done      <= 1'b0;
      wr_from_flush <= 1'b0;
      rle_size      <= '0;
    end else begin
      if (accept) begin
        rd_addr    <= message_addr[ADDR_W-1:0];
        hdr_addr   <= rle_addr[ADDR_W-1:0];
        wr_addr    <= rle_addr[ADDR_W-1:0] + (HDR_EN ? STEP : '0);
        remaining  <= message_size;
        msg_size_q <= message_size;
        byte_idx   <= '0;
        word_bytes <= '0;
        have_run   <= 1'b0;
        emit_sym   <= 1'b0;
        hdr_done   <= 1'b0;
        rle_size   <= '0;
      end
      if (capture) begin
        word_q     <= port_A_data_out;
        byte_idx   <= '0;
        word_bytes <= next_wb;
        remaining  <= remaining - 32'(next_wb);
        rd_addr    <= rd_addr + STEP;
      end
      if (consume) byte_idx <= byte_idx + BI_W'(1);
      if (run_new) begin
        cur_sym  <= cur_byte;
        cur_cnt  <= COUNT_W'(1);
        have_run <= 1'b1;
      end
      if (run_inc)  cur_cnt  <= cur_cnt + COUNT_W'(1);
      if (emit_set) emit_sym <= 1'b1;
      if (emit_clr) emit_sym <= 1'b0;
      if (run_end)  have_run <= 1'b0;
      if (push)     rle_size <= rle_size + 32'd1;
      if (hdr_wr) begin
        hdr_done <= 1'b1;
        rle_size <= rle_size + 32'(NB);
      end
      if (word_wr) wr_addr <= wr_addr + STEP;
      if (to_wr)   wr_from_flush <= (state == FLUSH);
    end
  end

endmodule
